// File: rtl/matmul_mac_array_if.sv
// Beat/result bundle for matmul_mac_array.
// slave  : the MAC array side (takes beats, produces results).
// master : the producer/consumer side (offers beats, takes results).
interface matmul_mac_array_if #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int KMAX  = 256
);
  localparam int CW = $clog2(KMAX + 1);

  logic                   en_i;
  logic                   valid_i;
  logic                   signed_i;
  logic [LANES*DW-1:0]    din_i;
  logic [DW-1:0]          win_i;
  logic                   in_rdy_o;
  logic                   vld_o;
  logic                   rdy_i;
  logic [LANES*ACC_W-1:0] matmul_o;
  logic [CW-1:0]          cnt_o;
  logic                   len_err_o;
  logic                   ovf_o;

  modport master (
    output en_i, valid_i, signed_i, din_i, win_i, rdy_i,
    input  in_rdy_o, vld_o, matmul_o, cnt_o, len_err_o, ovf_o
  );

  modport slave (
    input  en_i, valid_i, signed_i, din_i, win_i, rdy_i,
    output in_rdy_o, vld_o, matmul_o, cnt_o, len_err_o, ovf_o
  );
endinterface

// File: rtl/matmul_mac_array.sv
// Vector-by-scalar multiply-accumulate array.
// Each accepted beat adds din[lane]*win into a per-lane accumulator; a group
// closes on valid_i or on the KMAX-th beat and lands in a held output register.
// Optional macro MATMUL_SAT_EN: saturating accumulation with sticky ovf_o;
// without it accumulation wraps and ovf_o is 0.

// One lane: product, extend, add (optionally saturating), accumulator and
// output register.
module matmul_mac_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    din,
  input  logic [DW-1:0]    win,
  input  logic             sgn,
  input  logic             acc_en,
  input  logic             close,
  output logic [ACC_W-1:0] res,
  output logic             sat
);
  logic [2*DW-1:0]  prod_s, prod_u;
  logic [ACC_W-1:0] prod_x, acc_q, res_q, sum;

  // Full-width products; the signed one works on sign-extended operands.
  assign prod_s = $signed({{DW{din[DW-1]}}, din}) * $signed({{DW{win[DW-1]}}, win});
  assign prod_u = {{DW{1'b0}}, din} * {{DW{1'b0}}, win};
  assign prod_x = sgn ? ACC_W'($signed(prod_s)) : ACC_W'(prod_u);

`ifdef MATMUL_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] sum_x;
  logic           s_ovf;

  assign sum_x = {1'b0, acc_q} + {1'b0, prod_x};
  // Signed overflow: same-sign operands, result sign flipped.
  assign s_ovf = (acc_q[ACC_W-1] == prod_x[ACC_W-1]) &&
                 (sum_x[ACC_W-1] != acc_q[ACC_W-1]);

  // Clamp to the mode's range; unsigned products only overflow upward.
  always_comb begin
    sum = sum_x[ACC_W-1:0];
    sat = 1'b0;
    if (sgn && s_ovf) begin
      sat = 1'b1;
      sum = acc_q[ACC_W-1] ? SMIN : SMAX;
    end else if (!sgn && sum_x[ACC_W]) begin
      sat = 1'b1;
      sum = '1;
    end
  end
`else
  assign sum = acc_q + prod_x;
  assign sat = 1'b0;
`endif

  // Accumulate on each beat; a closing beat moves the sum out and clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (acc_en) begin
      acc_q <= close ? '0 : sum;
      if (close) res_q <= sum;
    end
  end

  assign res = res_q;
endmodule

module matmul_mac_array #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int KMAX  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  matmul_mac_array_if.slave io
);
  localparam int CW = $clog2(KMAX + 1);

  typedef enum logic {IDLE, ACC} state_e;

  state_e                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic                          grp_signed_q, vld_q, len_err_q;
  logic                          in_rdy, accept, kmax_hit, close, cur_signed;
  logic [LANES-1:0][DW-1:0]      din_v;
  logic [LANES-1:0][ACC_W-1:0]   res_v;

  assign din_v = io.din_i;

  // A drain frees the register in the same cycle a new beat arrives.
  assign in_rdy   = !vld_q || io.rdy_i;
  assign accept   = io.en_i && in_rdy;
  // KMAX close only counts as a length error when valid_i didn't close it.
  assign kmax_hit = (cnt_q == CW'(KMAX - 1)) && !io.valid_i;
  assign close    = accept && (io.valid_i || kmax_hit);
  // The first beat uses signed_i live; later beats use the latched mode.
  assign cur_signed = (state_q == IDLE) ? io.signed_i : grp_signed_q;

  // Group control FSM plus result-valid / length-error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grp_signed_q <= 1'b0;
      vld_q        <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (state_q == IDLE) grp_signed_q <= io.signed_i;
        if (close) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= ACC;
          cnt_q   <= cnt_q + 1'b1;
        end
      end
      if (close) begin
        vld_q     <= 1'b1;
        len_err_q <= kmax_hit;
      end else if (io.rdy_i) begin
        vld_q     <= 1'b0;
      end
    end
  end

`ifdef MATMUL_SAT_EN
  logic [LANES-1:0] sat_v;
  logic             grp_ovf_q, ovf_q;

  // Sticky per-group saturation flag, handed to ovf_o on close.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grp_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      if (close) begin
        grp_ovf_q <= 1'b0;
        ovf_q     <= grp_ovf_q | (|sat_v);
      end else begin
        grp_ovf_q <= grp_ovf_q | (|sat_v);
      end
    end
  end

  assign io.ovf_o = ovf_q;
`else
  assign io.ovf_o = 1'b0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    matmul_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .din    (din_v[l]),
      .win    (io.win_i),
      .sgn    (cur_signed),
      .acc_en (accept),
      .close  (close),
      .res    (res_v[l]),
`ifdef MATMUL_SAT_EN
      .sat    (sat_v[l])
`else
      .sat    ()
`endif
    );
  end

  assign io.in_rdy_o  = in_rdy;
  assign io.vld_o     = vld_q;
  assign io.matmul_o  = res_v;
  assign io.cnt_o     = cnt_q;
  assign io.len_err_o = len_err_q;
endmodule

// File: tb/tb_matmul_mac_array.sv
// Directed bench: default array, a 16-bit-accumulator array for saturation
// and a KMAX=4 array for auto-close; all share one stimulus bus.
module tb_matmul_mac_array;
  logic         clk = 1'b0;
  logic         rst, en, valid, sgn, rdy;
  logic [127:0] din;
  logic [7:0]   win;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  matmul_mac_array_if #(.LANES(16), .DW(8), .ACC_W(32), .KMAX(256)) ma ();
  matmul_mac_array_if #(.LANES(16), .DW(8), .ACC_W(16), .KMAX(256)) sa ();
  matmul_mac_array_if #(.LANES(16), .DW(8), .ACC_W(32), .KMAX(4))   ka ();

  assign ma.en_i = en;  assign ma.valid_i = valid; assign ma.signed_i = sgn;
  assign ma.din_i = din; assign ma.win_i = win;    assign ma.rdy_i = rdy;
  assign sa.en_i = en;  assign sa.valid_i = valid; assign sa.signed_i = sgn;
  assign sa.din_i = din; assign sa.win_i = win;    assign sa.rdy_i = rdy;
  assign ka.en_i = en;  assign ka.valid_i = valid; assign ka.signed_i = sgn;
  assign ka.din_i = din; assign ka.win_i = win;    assign ka.rdy_i = rdy;

  matmul_mac_array #(.LANES(16), .DW(8), .ACC_W(32), .KMAX(256)) u_main (
    .clk_i(clk), .rst_i(rst), .io(ma.slave));
  matmul_mac_array #(.LANES(16), .DW(8), .ACC_W(16), .KMAX(256)) u_sat (
    .clk_i(clk), .rst_i(rst), .io(sa.slave));
  matmul_mac_array #(.LANES(16), .DW(8), .ACC_W(32), .KMAX(4)) u_kmax (
    .clk_i(clk), .rst_i(rst), .io(ka.slave));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic beat(input logic v, input logic s, input logic [7:0] d, input logic [7:0] w);
    en = 1'b1; valid = v; sgn = s; din = {16{d}}; win = w;
    @(posedge clk); #1;
    en = 1'b0; valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; sgn = 1'b0; rdy = 1'b0;
    din = '0; win = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    chk("rst_vld",     ma.vld_o,     1'b0);
    chk("rst_matmul",  ma.matmul_o,  '0);
    chk("rst_cnt",     ma.cnt_o,     9'd0);
    chk("rst_ovf",     ma.ovf_o,     1'b0);
    chk("rst_len_err", ma.len_err_o, 1'b0);
    chk("rst_in_rdy",  ma.in_rdy_o,  1'b1);

    // Basic unsigned group: lanes=1, win=1..8 -> 36, held (rdy=0)
    for (int w = 1; w <= 8; w++) begin
      beat(w == 8, 1'b0, 8'd1, 8'(w));
      if (w == 3) chk("basic_cnt3", ma.cnt_o, 9'd3);
    end
    chk("basic_vld",     ma.vld_o,     1'b1);
    chk("basic_sum",     ma.matmul_o,  {16{32'd36}});
    chk("basic_len_err", ma.len_err_o, 1'b0);
    chk("basic_cnt0",    ma.cnt_o,     9'd0);

    // Backpressure: offered beats are ignored while the result is held
    en = 1'b1; valid = 1'b0; sgn = 1'b0; din = {16{8'd1}}; win = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold",   ma.matmul_o, {16{32'd36}});
      chk("bp_in_rdy", ma.in_rdy_o, 1'b0);
      chk("bp_cnt",    ma.cnt_o,    9'd0);
    end
    // Drain plus a 1-beat group on the same edge: reload, vld stays 1
    rdy = 1'b1;
    beat(1'b1, 1'b0, 8'd2, 8'd3);
    chk("reload_vld", ma.vld_o,    1'b1);
    chk("reload_sum", ma.matmul_o, {16{32'd6}});
    @(posedge clk); #1;
    rdy = 1'b0; #1;
    chk("drain_vld",    ma.vld_o,    1'b0);
    chk("drain_in_rdy", ma.in_rdy_o, 1'b1);

    // Signed vs unsigned: lanes=FF, win=2, 4 beats; mode from first beat only
    do_reset();
    for (int i = 0; i < 4; i++) beat(i == 3, i == 0, 8'hFF, 8'd2);
    chk("signed_sum", ma.matmul_o, {16{32'hFFFFFFF8}});
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("signed_drain", ma.vld_o, 1'b0);
    for (int i = 0; i < 4; i++) beat(i == 3, i != 0, 8'hFF, 8'd2);
    chk("unsigned_sum", ma.matmul_o, {16{32'd2040}});
    chk("unsigned_vld", ma.vld_o,    1'b1);

    // Saturation / wrap on 16-bit accumulators: 2 x (FF*FF)
    do_reset();
    beat(1'b0, 1'b0, 8'hFF, 8'hFF);
    beat(1'b1, 1'b0, 8'hFF, 8'hFF);
`ifdef MATMUL_SAT_EN
    chk("sat_lane", sa.matmul_o, {16{16'hFFFF}});
    chk("sat_ovf",  sa.ovf_o,    1'b1);
`else
    chk("wrap_lane", sa.matmul_o, {16{16'hFC02}});
    chk("wrap_ovf",  sa.ovf_o,    1'b0);
`endif
    chk("sat_vld", sa.vld_o, 1'b1);

    // KMAX=4 auto-close: 4 beats of 1*3, no valid_i
    do_reset();
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 8'd1, 8'd3);
    chk("kmax_vld",     ka.vld_o,     1'b1);
    chk("kmax_sum",     ka.matmul_o,  {16{32'd12}});
    chk("kmax_len_err", ka.len_err_o, 1'b1);
    chk("kmax_cnt0",    ka.cnt_o,     3'd0);
    rdy = 1'b1;
    beat(1'b0, 1'b0, 8'd1, 8'd1);
    rdy = 1'b0;
    chk("kmax_next_cnt", ka.cnt_o, 3'd1);
    chk("kmax_next_vld", ka.vld_o, 1'b0);

    // Reset while a result is held
    do_reset();
    beat(1'b1, 1'b0, 8'd1, 8'd5);
    chk("held_sum", ma.matmul_o, {16{32'd5}});
    do_reset();
    chk("rst_held_vld",    ma.vld_o,    1'b0);
    chk("rst_held_matmul", ma.matmul_o, '0);
    chk("rst_held_in_rdy", ma.in_rdy_o, 1'b1);

    // Reset after 3 of 8 beats, then a fresh 8-beat group
    for (int w = 1; w <= 3; w++) beat(1'b0, 1'b0, 8'd1, 8'(w));
    chk("mid_cnt3", ma.cnt_o, 9'd3);
    do_reset();
    chk("mid_rst_cnt",    ma.cnt_o,    9'd0);
    chk("mid_rst_vld",    ma.vld_o,    1'b0);
    chk("mid_rst_matmul", ma.matmul_o, '0);
    for (int w = 1; w <= 8; w++) beat(w == 8, 1'b0, 8'd1, 8'(w));
    chk("fresh_sum", ma.matmul_o, {16{32'd36}});
    chk("fresh_vld", ma.vld_o,    1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_mac_array.md
# matmul_mac_array

Parametrised vector-by-scalar multiply-accumulate array and the successor to the fixed 16-lane, 8-bit matmul. Each accepted beat multiplies every lane of `din_i` by the scalar weight `win_i` and adds the product into a per-lane accumulator. A group of beats closes on `valid_i`, or automatically at `KMAX` beats. The closed result moves to an output register held under a valid/ready handshake, and the next group can start in the same cycle. Per-group signed/unsigned mode and an optional saturation mode are new in this generation.

## Interface
- `LANES`, default 16: number of parallel lanes.
- `DW`, default 8: width of each `din_i` element and of `win_i`.
- `ACC_W`, default 32: accumulator and output width per lane; must be ≥ 2*DW.
- `KMAX`, default 256: maximum number of beats per group; must be ≥ 2.

Ports:
- `clk_i` in, 1: the single clock; all logic is on the rising edge.
- `rst_i` in, 1: reset, synchronous and active-high.
- `en_i` in, 1: beat offered.
- `valid_i` in, 1: the offered beat is the last beat of its group.
- `signed_i` in, 1: selects two's-complement arithmetic; sampled only on the first beat of a group.
- `din_i` in, LANES*DW: lane vector; lane 0 is bits [DW-1:0].
- `win_i` in, DW: scalar weight.
- `in_rdy_o` out, 1: the block can accept a beat this cycle.
- `vld_o` out, 1: the output register holds a result.
- `rdy_i` in, 1: the downstream consumer takes the result.
- `matmul_o` out, LANES*ACC_W: result; lane 0 is bits [ACC_W-1:0].
- `cnt_o` out, $clog2(KMAX+1): number of beats accepted in the open group.
- `len_err_o` out, 1: the result was closed by the `KMAX` limit, not by `valid_i`.
- `ovf_o` out, 1: at least one lane saturated in this result.

## Operation
- A beat is accepted when `en_i && in_rdy_o`.
- `in_rdy_o = !vld_o || rdy_i`. It is combinational, so a drain and a new beat can happen in the same cycle.
- Beats offered while `in_rdy_o` is low are ignored. The upstream must hold them.
- Control FSM:
  - IDLE: accumulators are zero and `cnt_o` is 0. An accepted beat latches `signed_i` into the group mode and moves to ACC. If that beat also has `valid_i`, it closes the group immediately and the FSM stays in IDLE.
  - ACC: each accepted beat adds its product and increments `cnt_o`. The group closes on an accepted beat that has `valid_i`, or on the `KMAX`-th accepted beat. The `KMAX` case sets `len_err` for that result. On close, the FSM returns to IDLE.
- Close action, all at the same edge:
  - Output register ← accumulator + current product.
  - Accumulators and `cnt_o` clear.
  - `vld_o` sets.
  - `ovf_o` and `len_err_o` load the group's flags.
- Arithmetic:
  - Each product is 2*DW bits.
  - In signed mode, the product is sign-extended to ACC_W. In unsigned mode, it is zero-extended.
  - Addition is done at ACC_W bits.
  - `signed_i` on non-first beats is ignored.
- Handshake:
  - The result and flags stay stable while `vld_o && !rdy_i`.
  - With `vld_o && rdy_i`, the register drains. If a close happens at the same edge, the register reloads and `vld_o` stays 1. Otherwise `vld_o` drops to 0.
- Reset, including mid-group or mid-hold:
  - Next state is IDLE.
  - Accumulators, output register and `cnt_o` clear.
  - `vld_o`, `ovf_o` and `len_err_o` go to 0.
  - `in_rdy_o` is 1 after reset.
- `en_i` low: the state is held and there is no accumulation.

## Timing
- Close-to-output latency is 1 cycle. If the last beat is accepted at edge N, `vld_o` and the result are visible after edge N.
- Throughput is one beat per cycle with no bubble between groups, provided `rdy_i` is held high.
- Reset values:
  - `vld_o` 0, `matmul_o` 0, `cnt_o` 0, `ovf_o` 0, `len_err_o` 0, `in_rdy_o` 1.
- The multipliers may be pipelined internally only if the 1-cycle close latency and the accept rule stay exactly as specified above.

## Configuration
- `MATMUL_SAT_EN` defined: each lane accumulator saturates on every add.
  - Signed mode limits: [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned mode limits: [0, 2^ACC_W-1].
  - Any saturation event in a group sets that group's sticky `ovf_o`.
- `MATMUL_SAT_EN` undefined: accumulation wraps modulo 2^ACC_W, and `ovf_o` is tied to 0.

## Test plan
- Basic unsigned group, default parameters: 8 beats with every lane of `din_i` = 1, `win_i` = 1..8, and `valid_i` on beat 8. Required: one cycle later `vld_o` = 1 and every lane = 36; `len_err_o` = 0.
- Signed versus unsigned: 4 beats with lanes = 8'hFF, `win_i` = 2. With `signed_i` = 1, every lane = 32'hFFFFFFF8. With `signed_i` = 0, every lane = 2040.
- Backpressure: `rdy_i` = 0 for 5 cycles after a close.
  - `matmul_o` stays stable and `in_rdy_o` = 0.
  - Held beats are not counted.
  - `rdy_i` = 1 together with a 1-beat `valid_i` group: the register reloads and `vld_o` stays 1.
- Saturation with `ACC_W` = 16, unsigned, 2 beats of lanes = 8'hFF and `win_i` = 8'hFF:
  - With `MATMUL_SAT_EN`: lane = 16'hFFFF and `ovf_o` = 1.
  - Without it: lane = 16'hFC02 and `ovf_o` = 0.
- KMAX auto-close with `KMAX` = 4: 4 beats of lanes = 1, `win_i` = 3, no `valid_i`. Required: lanes = 12 and `len_err_o` = 1. The next beat starts a new group with `cnt_o` = 1.
- Reset mid-group: assert `rst_i` after 3 of 8 beats, with an unconsumed result held. Required: `vld_o` = 0, `cnt_o` = 0 and `matmul_o` = 0. A following 8-beat group gives the correct fresh sum (36).
